// File: rtl/rpn_evaluator.sv
// Postfix token-queue evaluator: one pass over the parser's output queue per start,
// producing a signed fixed-point result for the sampled x, or an error code.
module rpn_evaluator #(
    parameter int INTEGER_PART_WIDTH    = 8,
    parameter int FRACTIONAL_PART_WIDTH = 8,
    parameter int OUTPUT_QUEUE_SIZE     = 64,
    parameter int STACK_SIZE            = 16,
    localparam int NW = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH,
    localparam int IW = $clog2(OUTPUT_QUEUE_SIZE) + 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [NW-1:0] x,
    input  logic [IW-1:0] queue_length,
    output logic          queue_read,
    output logic [IW-1:0] queue_read_index,
    input  logic [NW:0]   queue_read_data,
    input  logic          queue_read_valid,
    output logic          busy,
    output logic          done,
    output logic [NW-1:0] result,
    output logic          error,
    output logic [2:0]    error_code
);

    localparam int FW = FRACTIONAL_PART_WIDTH;
    localparam int DW = NW + FW;
    localparam int SW = $clog2(STACK_SIZE + 1);
    localparam int AW = $clog2(STACK_SIZE);
    localparam logic [NW-1:0] ONE = NW'(1 << FW);

    localparam logic [2:0] OP_PLUS = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_DIV  = 3'd3;
    localparam logic [2:0] OP_VAR  = 3'd6;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_WAIT, S_EXEC, S_MUL, S_DIV, S_POW, S_FINISH, S_ERR, S_DONE
    } state_t;

    function automatic logic [NW-1:0] qmul(input logic [NW-1:0] a, input logic [NW-1:0] b);
        logic signed [2*NW-1:0] sa;
        logic signed [2*NW-1:0] sb;
        sa = {{NW{a[NW-1]}}, a};
        sb = {{NW{b[NW-1]}}, b};
        return NW'((sa * sb) >>> FW);
    endfunction

    function automatic logic [NW-1:0] mag(input logic [NW-1:0] v);
        return v[NW-1] ? -v : v;
    endfunction

    state_t        state_q;
    logic [NW-1:0] stack_q [STACK_SIZE];
    logic [SW-1:0] sp_q;
    logic [IW-1:0] idx_q, len_q;
    logic [NW-1:0] x_q;
    logic [NW:0]   entry_q;
    logic [NW-1:0] op_a_q, op_b_q, acc_q, dvs_q, rem_q, cnt_q;
    logic [DW-1:0] quot_q;
    logic          neg_q;
    logic [2:0]    ecode_q;
    logic          busy_q, done_q, error_q;
    logic [NW-1:0] result_q;
    logic [2:0]    error_code_q;

    logic [NW-1:0] tos, nos, mul_res, acc_d, rem_d, div_res;
    logic [NW:0]   trial;
    logic [DW-1:0] quot_d;
    logic [AW-1:0] wr_idx;
    logic          is_push;

    assign tos     = stack_q[AW'(sp_q - SW'(1))];
    assign nos     = stack_q[AW'(sp_q - SW'(2))];
    assign wr_idx  = AW'(sp_q - SW'(2));
    assign mul_res = qmul(op_a_q, op_b_q);
    assign acc_d   = qmul(acc_q, op_a_q);
    assign is_push = !entry_q[NW] || (entry_q[2:0] == OP_VAR);

    // One restoring-division step: shift the next dividend bit into the remainder.
    always_comb begin
        trial = {rem_q, quot_q[DW-1]};
        if (trial >= {1'b0, dvs_q}) begin
            rem_d  = NW'(trial - {1'b0, dvs_q});
            quot_d = {quot_q[DW-2:0], 1'b1};
        end else begin
            rem_d  = trial[NW-1:0];
            quot_d = {quot_q[DW-2:0], 1'b0};
        end
    end

    assign div_res = neg_q ? -quot_d[NW-1:0] : quot_d[NW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sp_q         <= '0;
            idx_q        <= '0;
            len_q        <= '0;
            x_q          <= '0;
            entry_q      <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            acc_q        <= '0;
            dvs_q        <= '0;
            rem_q        <= '0;
            cnt_q        <= '0;
            quot_q       <= '0;
            neg_q        <= 1'b0;
            ecode_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            result_q     <= '0;
            error_code_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: if (start) begin
                    x_q          <= x;
                    len_q        <= queue_length;
                    idx_q        <= '0;
                    sp_q         <= '0;
                    error_q      <= 1'b0;
                    error_code_q <= '0;
                    busy_q       <= 1'b1;
                    state_q      <= S_FETCH;
                end
                S_FETCH: state_q <= (idx_q == len_q) ? S_FINISH : S_WAIT;
                S_WAIT: if (queue_read_valid) begin
                    entry_q <= queue_read_data;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    idx_q   <= idx_q + IW'(1);
                    state_q <= S_FETCH;
                    if (is_push) begin
                        if (sp_q == SW'(STACK_SIZE)) begin
                            ecode_q <= 3'd2;
                            state_q <= S_ERR;
                        end else begin
                            stack_q[AW'(sp_q)] <= entry_q[NW] ? x_q : entry_q[NW-1:0];
                            sp_q <= sp_q + SW'(1);
                        end
                    end else if (entry_q[2:0] == 3'd5 || entry_q[2:0] == 3'd7) begin
                        ecode_q <= 3'd5;
                        state_q <= S_ERR;
                    end else if (sp_q < SW'(2)) begin
                        ecode_q <= 3'd1;
                        state_q <= S_ERR;
                    end else begin
                        case (entry_q[2:0])
                            OP_PLUS: begin
                                stack_q[wr_idx] <= nos + tos;
                                sp_q <= sp_q - SW'(1);
                            end
                            OP_SUB: begin
                                stack_q[wr_idx] <= nos - tos;
                                sp_q <= sp_q - SW'(1);
                            end
                            OP_MUL: begin
                                op_a_q  <= nos;
                                op_b_q  <= tos;
                                state_q <= S_MUL;
                            end
                            OP_DIV: begin
                                if (tos == '0) begin
                                    ecode_q <= 3'd3;
                                    state_q <= S_ERR;
                                end else begin
                                    quot_q  <= {mag(nos), {FW{1'b0}}};
                                    rem_q   <= '0;
                                    dvs_q   <= mag(tos);
                                    neg_q   <= nos[NW-1] ^ tos[NW-1];
                                    cnt_q   <= NW'(DW - 1);
                                    state_q <= S_DIV;
                                end
                            end
                            default: begin
                                if (tos[NW-1]) begin
                                    ecode_q <= 3'd4;
                                    state_q <= S_ERR;
                                end else begin
                                    op_a_q  <= nos;
                                    acc_q   <= ONE;
                                    cnt_q   <= tos >> FW;
                                    state_q <= S_POW;
                                end
                            end
                        endcase
                    end
                end
                S_MUL: begin
                    stack_q[wr_idx] <= mul_res;
                    sp_q    <= sp_q - SW'(1);
                    state_q <= S_FETCH;
                end
                S_DIV: begin
                    rem_q  <= rem_d;
                    quot_q <= quot_d;
                    cnt_q  <= cnt_q - NW'(1);
                    if (cnt_q == '0) begin
                        stack_q[wr_idx] <= div_res;
                        sp_q    <= sp_q - SW'(1);
                        state_q <= S_FETCH;
                    end
                end
                // A zero exponent still spends one cycle here and writes 1.0.
                S_POW: begin
                    if (cnt_q <= NW'(1)) begin
                        stack_q[wr_idx] <= (cnt_q == '0) ? acc_q : acc_d;
                        sp_q    <= sp_q - SW'(1);
                        state_q <= S_FETCH;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q - NW'(1);
                    end
                end
                S_FINISH: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_DONE;
                    if (sp_q == SW'(1)) begin
                        result_q <= tos;
                    end else begin
                        result_q     <= '0;
                        error_q      <= 1'b1;
                        error_code_q <= 3'd6;
                    end
                end
                S_ERR: begin
                    result_q     <= '0;
                    error_q      <= 1'b1;
                    error_code_q <= ecode_q;
                    done_q       <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= S_DONE;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign queue_read       = (state_q == S_FETCH) && (idx_q != len_q);
    assign queue_read_index = idx_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign result           = result_q;
    assign error            = error_q;
    assign error_code       = error_code_q;

endmodule

// File: tb/tb_rpn_evaluator.sv
// Directed bench for rpn_evaluator: a queue memory model answers read strobes
// with a fixed or random delay; results and latencies are compared to hand-computed values.
module tb_rpn_evaluator;

    localparam int NW = 16;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [NW-1:0] x = '0;
    logic [IW-1:0] queue_length = '0;
    logic          queue_read;
    logic [IW-1:0] queue_read_index;
    logic [NW:0]   queue_read_data = '0;
    logic          queue_read_valid = 1'b0;
    logic          busy, done, error;
    logic [NW-1:0] result;
    logic [2:0]    error_code;

    logic [NW:0] mem [64];
    int n_checks = 0;
    int n_fail = 0;
    int strobes = 0;
    bit rand_dly = 1'b0;

    int            lat;
    logic          r_busy1;
    logic [NW-1:0] r_res;
    logic          r_err;
    logic [2:0]    r_code;
    int            done_seen;

    rpn_evaluator dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .x                (x),
        .queue_length     (queue_length),
        .queue_read       (queue_read),
        .queue_read_index (queue_read_index),
        .queue_read_data  (queue_read_data),
        .queue_read_valid (queue_read_valid),
        .busy             (busy),
        .done             (done),
        .result           (result),
        .error            (error),
        .error_code       (error_code)
    );

    always #5 clk = ~clk;

    // Queue memory: sees the strobe mid-cycle, returns data d cycles later for one cycle.
    initial begin
        int d;
        logic [IW-1:0] a;
        forever begin
            @(negedge clk);
            if (queue_read && !rst) begin
                strobes = strobes + 1;
                a = queue_read_index;
                d = rand_dly ? int'($urandom_range(5, 1)) : 1;
                @(posedge clk);
                repeat (d - 1) @(posedge clk);
                #1;
                queue_read_data  = mem[a[5:0]];
                queue_read_valid = 1'b1;
                @(posedge clk);
                #1 queue_read_valid = 1'b0;
            end
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run(input logic [NW-1:0] xv, input int len);
        int k;
        strobes = 0;
        @(negedge clk);
        x = xv;
        queue_length = IW'(len);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        r_busy1 = busy;
        k = 1;
        while (!done && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk_eq("done_seen", 32'(done), 32'd1);
        lat    = k;
        r_res  = result;
        r_err  = error;
        r_code = error_code;
    endtask

    task automatic expect_ok(input string tag, input logic [NW-1:0] exp);
        chk_eq({tag, "_result"}, 32'(r_res), 32'(exp));
        chk_eq({tag, "_error"}, 32'(r_err), 32'd0);
    endtask

    task automatic expect_err(input string tag, input logic [2:0] code);
        chk_eq({tag, "_error"}, 32'(r_err), 32'd1);
        chk_eq({tag, "_code"}, 32'(r_code), 32'(code));
        chk_eq({tag, "_result"}, 32'(r_res), 32'd0);
    endtask

    task automatic load_x_plus;
        mem[0] = 17'h1_0006; mem[1] = 17'h0_0180; mem[2] = 17'h1_0000;
    endtask

    task automatic load_div;
        mem[0] = 17'h0_0700; mem[1] = 17'h0_0200; mem[2] = 17'h1_0003;
    endtask

    task automatic load_neg_div;
        mem[0] = 17'h0_0000; mem[1] = 17'h0_0700; mem[2] = 17'h1_0001;
        mem[3] = 17'h0_0200; mem[4] = 17'h1_0003;
    endtask

    task automatic load_pow;
        mem[0] = 17'h1_0006; mem[1] = 17'h0_0300; mem[2] = 17'h1_0004;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_eq("rst_busy", 32'(busy), 32'd0);
        chk_eq("rst_done", 32'(done), 32'd0);
        chk_eq("rst_queue_read", 32'(queue_read), 32'd0);
        chk_eq("rst_index", 32'(queue_read_index), 32'd0);
        chk_eq("rst_result", 32'(result), 32'd0);
        chk_eq("rst_error", 32'(error), 32'd0);
        chk_eq("rst_code", 32'(error_code), 32'd0);
        rst = 1'b0;

        run(16'h0000, 0);
        chk_eq("len0_busy", 32'(r_busy1), 32'd1);
        chk_eq("len0_latency", 32'(lat), 32'd3);
        expect_err("len0", 3'd6);
        @(negedge clk);
        chk_eq("len0_done_pulse", 32'(done), 32'd0);
        chk_eq("len0_busy_clear", 32'(busy), 32'd0);

        load_x_plus();
        run(16'h0200, 3);
        expect_ok("x_plus", 16'h0380);
        chk_eq("x_plus_strobes", 32'(strobes), 32'd3);
        chk_eq("x_plus_latency", 32'(lat), 32'd12);

        load_div();
        run(16'h0000, 3);
        expect_ok("div", 16'h0380);
        chk_eq("div_latency", 32'(lat), 32'd36);

        load_neg_div();
        run(16'h0000, 5);
        expect_ok("neg_div", 16'hFC80);

        mem[0] = 17'h0_0180; mem[1] = 17'h1_0006; mem[2] = 17'h1_0002;
        run(16'hFE00, 3);
        expect_ok("mul", 16'hFD00);
        chk_eq("mul_latency", 32'(lat), 32'd13);

        mem[0] = 17'h0_1000; mem[1] = 17'h0_1000; mem[2] = 17'h1_0002;
        run(16'h0000, 3);
        expect_ok("mul_wrap", 16'h0000);

        mem[0] = 17'h0_7F00; mem[1] = 17'h0_7F00; mem[2] = 17'h1_0000;
        run(16'h0000, 3);
        expect_ok("add_wrap", 16'hFE00);

        load_pow();
        run(16'hFE80, 3);
        expect_ok("pow", 16'hFCA0);
        chk_eq("pow_latency", 32'(lat), 32'd15);

        // Reset while the divider is iterating.
        load_div();
        @(negedge clk);
        queue_length = IW'(3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        chk_eq("mid_div_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_eq("mid_rst_busy", 32'(busy), 32'd0);
        chk_eq("mid_rst_done", 32'(done), 32'd0);
        chk_eq("mid_rst_queue_read", 32'(queue_read), 32'd0);
        chk_eq("mid_rst_index", 32'(queue_read_index), 32'd0);
        chk_eq("mid_rst_result", 32'(result), 32'd0);
        chk_eq("mid_rst_error", 32'(error), 32'd0);
        rst = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk_eq("mid_rst_no_done", 32'(done_seen), 32'd0);

        run(16'h0000, 3);
        expect_ok("div_after_rst", 16'h0380);

        mem[0] = 17'h1_0006; mem[1] = 17'h0_0000; mem[2] = 17'h1_0004;
        run(16'hFE80, 3);
        expect_ok("pow_zero", 16'h0100);

        mem[0] = 17'h0_0100; mem[1] = 17'h0_0000; mem[2] = 17'h1_0003;
        run(16'h0000, 3);
        expect_err("div_zero", 3'd3);

        mem[0] = 17'h1_0000;
        run(16'h0000, 1);
        expect_err("underflow", 3'd1);

        mem[0] = 17'h0_0100; mem[1] = 17'h0_0200;
        run(16'h0000, 2);
        expect_err("depth2", 3'd6);

        for (int i = 0; i < 17; i++) mem[i] = {1'b0, 16'(i * 256)};
        run(16'h0000, 17);
        expect_err("overflow", 3'd2);
        chk_eq("overflow_strobes", 32'(strobes), 32'd17);

        mem[0] = 17'h1_0005;
        run(16'h0000, 1);
        expect_err("opcode5", 3'd5);

        mem[0] = 17'h0_0100; mem[1] = 17'h1_0007;
        run(16'h0000, 2);
        expect_err("opcode7", 3'd5);

        mem[0] = 17'h0_0200; mem[1] = 17'h1_0006; mem[2] = 17'h1_0004;
        run(16'hFF00, 3);
        expect_err("neg_exp", 3'd4);

        rand_dly = 1'b1;
        for (int rep = 0; rep < 3; rep++) begin
            load_x_plus();
            run(16'h0200, 3);
            expect_ok("rnd_x_plus", 16'h0380);
            load_neg_div();
            run(16'h0000, 5);
            expect_ok("rnd_neg_div", 16'hFC80);
            load_pow();
            run(16'hFE80, 3);
            expect_ok("rnd_pow", 16'hFCA0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
